// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, types and helpers for the regfile_sb slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_DEPTH  = 32;
  localparam int REG_ADDR_W = $clog2(REG_DEPTH);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // True when the addressed register is the hard-wired zero register.
  function automatic logic is_hardwired(input logic addr_is_zero, input int zero_reg);
    return addr_is_zero && (zero_reg != 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy bits with issue/writeback priority and a
//               registered popcount of the busy vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [DEPTH-1:0]  busy_o,
  output logic [ADDR_W:0]   busy_count_o,
  output logic              wr_valid_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             set_valid;

  assign set_valid  = set_en_i && !is_hardwired(set_addr_i == '0, ZERO_REG);
  assign wr_valid_o = clr_en_i && !is_hardwired(clr_addr_i == '0, ZERO_REG);
  assign wr_addr_o  = clr_addr_i;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid_o) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_valid) begin
      busy_d[set_addr_i] = 1'b1;
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised two-read/one-write register file with an
//               integrated write-pending scoreboard.
//               Optional macro REGFILE_BYPASS_EN forwards the write port to
//               matching read ports in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int DEPTH    = REG_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              readBusy1,
  output logic              readBusy2,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic              issueEnable,
  input  logic [ADDR_W-1:0] issueAddr,
  output logic [ADDR_W:0]   busyCount
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_i        (reset),
    .set_en_i     (issueEnable),
    .set_addr_i   (issueAddr),
    .clr_en_i     (writeEnable),
    .clr_addr_i   (writeAddr),
    .busy_o       (busy),
    .busy_count_o (busyCount),
    .wr_valid_o   (wr_valid),
    .wr_addr_o    (wr_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_valid) begin
      mem_q[wr_addr] <= writeData;
    end
  end

  function automatic logic [DATA_W-1:0] port_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = mem_q[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (wr_addr == a)) begin
      d = writeData;
    end
`endif
    if (is_hardwired(a == '0, ZERO_REG)) begin
      d = '0;
    end
    return d;
  endfunction

  // A forwarded write retires the pending bit unless the same register is reissued.
  function automatic logic port_busy(input logic [ADDR_W-1:0] a);
    logic b;
    b = busy[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && (wr_addr == a)) begin
      b = issueEnable && (issueAddr == a);
    end
`endif
    if (is_hardwired(a == '0, ZERO_REG)) begin
      b = 1'b0;
    end
    return b;
  endfunction

  assign readData1 = port_data(readAddr1);
  assign readData2 = port_data(readAddr2);
  assign readBusy1 = port_busy(readAddr1);
  assign readBusy2 = port_busy(readAddr2);

endmodule

`default_nettype wire
